// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz VGA timing constants and coordinate type.
// Used by the sync generator, the data generator and the colour/ROM stages.
package vga_timing_pkg;
  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int H_DISPLAY = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int H_SYNC_START = H_DISPLAY + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

  localparam int V_DISPLAY = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int V_SYNC_START = V_DISPLAY + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int FRAME_CNT_W = 6;

  function automatic logic in_span(coord_t x, coord_t lo, coord_t hi);
    return (x >= lo) && (x <= hi);
  endfunction
endpackage

// File: rtl/vga_tick_div.sv
// Pixel-rate strobe: mod-CLK_DIV counter, p_tick on its terminal count.
// CLK_DIV legal range 1..16; CLK_DIV==1 gives a strobe on every clock.
module vga_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);
  localparam logic [3:0] DIV_MAX = 4'(CLK_DIV - 1);

  logic [3:0] div_q, div_d;

  assign div_d = (div_q == DIV_MAX) ? 4'd0 : div_q + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) div_q <= '0;
    else       div_q <= div_d;
  end

  // Masked during reset so no strobe appears on a cycle whose advance is cancelled.
  assign p_tick = (div_q == DIV_MAX) && !reset;
endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel divider, h/v counters, registered syncs, frame pulse.
// Optional frame counter enabled by defining VGA_SYNC_FRAME_CNT_EN.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int HDISP   = H_DISPLAY,
  parameter int HFP     = H_FP,
  parameter int HSW     = H_SYNC,
  parameter int HBP     = H_BP,
  parameter int VDISP   = V_DISPLAY,
  parameter int VFP     = V_FP,
  parameter int VSW     = V_SYNC,
  parameter int VBP     = V_BP
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   video_on,
  output logic                   p_tick,
  output logic [COORD_W-1:0]     pixel_x,
  output logic [COORD_W-1:0]     pixel_y,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);
  localparam coord_t H_VIS  = coord_t'(HDISP);
  localparam coord_t H_MAX  = coord_t'(HDISP + HFP + HSW + HBP - 1);
  localparam coord_t HS_BEG = coord_t'(HDISP + HFP);
  localparam coord_t HS_END = coord_t'(HDISP + HFP + HSW - 1);
  localparam coord_t V_VIS  = coord_t'(VDISP);
  localparam coord_t V_MAX  = coord_t'(VDISP + VFP + VSW + VBP - 1);
  localparam coord_t VS_BEG = coord_t'(VDISP + VFP);
  localparam coord_t VS_END = coord_t'(VDISP + VFP + VSW - 1);

  logic   tick;
  coord_t h_q, h_d, v_q, v_d;
  logic   hs_q, vs_q;

  vga_tick_div #(.CLK_DIV(CLK_DIV)) u_tick_div (
    .clk    (clk),
    .reset  (reset),
    .p_tick (tick)
  );

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (tick) begin
      if (h_q == H_MAX) begin
        h_d = '0;
        v_d = (v_q == V_MAX) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Syncs decode the next counts so they change on the same edge as pixel_x/pixel_y.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q  <= '0;
      v_q  <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      hs_q <= !in_span(h_d, HS_BEG, HS_END);
      vs_q <= !in_span(v_d, VS_BEG, VS_END);
    end
  end

  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign pixel_x     = h_q;
  assign pixel_y     = v_q;
  assign p_tick      = tick;
  assign video_on    = (h_q < H_VIS) && (v_q < V_VIS);
  assign frame_start = tick && (h_q == H_MAX) && (v_q == V_MAX);

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] fcnt_q;

  always_ff @(posedge clk) begin
    if (reset)            fcnt_q <= '0;
    else if (frame_start) fcnt_q <= fcnt_q + 1'b1;
  end

  assign frame_cnt = fcnt_q;
`else
  assign frame_cnt = '0;
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size timing at CLK_DIV=4 plus a shrunken-timing
// instance at CLK_DIV=1 so whole frames and the frame-counter wrap fit in a short run.
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  typedef struct packed {
    logic       hs, vs, von, tick;
    logic [9:0] x, y;
    logic       fs;
    logic [5:0] fc;
  } obs_t;

  typedef struct {
    int d, hd, hf, hs, hb, vd, vf, vs, vb;
  } cfg_t;

  localparam int A_DIV = 4;
  localparam int B_FRAME = 15 * 13;

  cfg_t CA, CB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1;
  logic hs_a, vs_a, von_a, tk_a, fs_a, hs_b, vs_b, von_b, tk_b, fs_b;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic [5:0] fc_a, fc_b;

  vga_sync_gen #(.CLK_DIV(A_DIV)) dut_a (
    .clk(clk), .reset(rst_a), .hsync(hs_a), .vsync(vs_a), .video_on(von_a),
    .p_tick(tk_a), .pixel_x(x_a), .pixel_y(y_a), .frame_start(fs_a), .frame_cnt(fc_a)
  );

  vga_sync_gen #(.CLK_DIV(1), .HDISP(8), .HFP(2), .HSW(3), .HBP(2),
                 .VDISP(6), .VFP(2), .VSW(2), .VBP(3)) dut_b (
    .clk(clk), .reset(rst_b), .hsync(hs_b), .vsync(vs_b), .video_on(von_b),
    .p_tick(tk_b), .pixel_x(x_b), .pixel_y(y_b), .frame_start(fs_b), .frame_cnt(fc_b)
  );

  int n_cmp = 0, n_bad = 0;
  int c_a = 0, c_b = 0;
  obs_t q_a[$], q_b[$];

  // Outputs as a closed-form function of clocks elapsed since the last reset edge.
  function automatic obs_t ref_model(cfg_t k, int c, bit r);
    obs_t o;
    int ht, vt, n, hx, vy;
    ht = k.hd + k.hf + k.hs + k.hb;
    vt = k.vd + k.vf + k.vs + k.vb;
    n  = c / k.d;
    hx = n % ht;
    vy = (n / ht) % vt;
    o.x    = 10'(hx);
    o.y    = 10'(vy);
    o.tick = !r && ((c % k.d) == k.d - 1);
    o.hs   = !(hx >= k.hd + k.hf && hx < k.hd + k.hf + k.hs);
    o.vs   = !(vy >= k.vd + k.vf && vy < k.vd + k.vf + k.vs);
    o.von  = (hx < k.hd) && (vy < k.vd);
    o.fs   = o.tick && hx == ht - 1 && vy == vt - 1;
`ifdef VGA_SYNC_FRAME_CNT_EN
    o.fc   = 6'((n / (ht * vt)) % 64);
`else
    o.fc   = 6'd0;
`endif
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("hs=%b vs=%b von=%b tick=%b x=%0d y=%0d fs=%b fc=%0d",
                     o.hs, o.vs, o.von, o.tick, o.x, o.y, o.fs, o.fc);
  endfunction

  task automatic cmp_obs(input string nm, input obs_t got, input obs_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got [%s] expected [%s]", nm, fmt(got), fmt(exp));
    end
  endtask

  task automatic cmp_int(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  // One clock of stimulus for instance w: advance the model, drive reset, queue expectation.
  task automatic step(input int w, input bit r);
    @(posedge clk);
    #1;
    if (w == 0) begin
      c_a = rst_a ? 0 : c_a + 1;
      rst_a = r;
      q_a.push_back(ref_model(CA, c_a, r));
    end else begin
      c_b = rst_b ? 0 : c_b + 1;
      rst_b = r;
      q_b.push_back(ref_model(CB, c_b, r));
    end
  endtask

  initial begin : mon_a
    obs_t g, e;
    int run = 0;
    bit run_ok = 1'b1;
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        g = {hs_a, vs_a, von_a, tk_a, x_a, y_a, fs_a, fc_a};
        cmp_obs("a_out", g, e);
        if (!hs_a) begin
          run++;
          if (rst_a) run_ok = 1'b0;
        end else begin
          if (run > 0 && run_ok) cmp_int("a_hsync_low_clks", run, H_SYNC * A_DIV);
          run = 0;
          run_ok = 1'b1;
        end
      end
    end
  end

  initial begin : mon_b
    obs_t g, e;
    int cyc = 0, last = -1;
    forever begin
      @(negedge clk);
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        g = {hs_b, vs_b, von_b, tk_b, x_b, y_b, fs_b, fc_b};
        cmp_obs("b_out", g, e);
        cyc++;
        if (rst_b) last = -1;
        if (fs_b) begin
          if (last >= 0) cmp_int("b_frame_period", cyc - last, B_FRAME);
          last = cyc;
        end
      end
    end
  end

  initial begin
    CA = '{A_DIV, H_DISPLAY, H_FP, H_SYNC, H_BP, V_DISPLAY, V_FP, V_SYNC, V_BP};
    CB = '{1, 8, 2, 3, 2, 6, 2, 2, 3};
    fork
      begin
        repeat (3) step(0, 1'b1);
        repeat (2 * H_TOTAL * A_DIV + 50) step(0, 1'b0);
        repeat (4) begin
          repeat ($urandom_range(3000, 800)) step(0, 1'b0);
          repeat ($urandom_range(3, 1)) step(0, 1'b1);
        end
        repeat (H_TOTAL * A_DIV + 100) step(0, 1'b0);
      end
      begin
        repeat (2) step(1, 1'b1);
        repeat (65 * B_FRAME + 20) step(1, 1'b0);
        repeat (5) begin
          repeat ($urandom_range(400, 50)) step(1, 1'b0);
          repeat ($urandom_range(2, 1)) step(1, 1'b1);
        end
        repeat (3 * B_FRAME) step(1, 1'b0);
      end
    join
    @(negedge clk);
    @(negedge clk);
    cmp_int("a_queue_drained", q_a.size(), 0);
    cmp_int("b_queue_drained", q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
